muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide execution unit. Operands come from the register file's
//   rs1/rs2 read ports. Result and rd tag go to the write-back mux, which drives the register
//   file dataIn/Addr3/regWrite. Shift-add multiply and restoring divide, one bit per cycle.
//   Fixed latency, except for the divide special cases.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//   clk        in   1     rising-edge clock; only clock
//   reset      in   1     synchronous, active-high reset
//   start      in   1     request; accepted only when busy==0
//   funct3     in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   op_a       in   XLEN  rs1 value (dividend / multiplicand)
//   op_b       in   XLEN  rs2 value (divisor / multiplier)
//   rd_in      in   5     destination register tag
//   busy       out  1     operation in flight; start ignored while high
//   done       out  1     one-cycle pulse; result/rd_out valid
//   result     out  XLEN  final value; held until next accepted start
//   rd_out     out  5     rd_in captured at accept; held with result
// BEHAVIOUR
//   Clock and reset: one clock (clk); reset is synchronous and active-high.
//   Reset (any state, incl. mid-operation):
//     state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0; in-flight op discarded.
//   States: IDLE -> RUN -> FINISH -> IDLE. Special case: IDLE -> FINISH_SPECIAL -> IDLE.
//   Accept at edge N (IDLE & start):
//     - Latch funct3, rd_in, |op_a|, |op_b| and the sign flags.
//     - Signedness: MULH signed x signed; MULHSU signed a x unsigned b; DIV/REM signed.
//     - busy=1 from edge N.
//   RUN:
//     - Exactly XLEN cycles (edges N+1..N+XLEN); counter 0..XLEN-1, then to FINISH.
//     - MUL: 2*XLEN-bit accumulator; add multiplicand if multiplier LSB set; shift.
//     - DIV: restoring; remainder shift-in dividend MSB; subtract divisor if no borrow;
//       quotient bit = !borrow.
//   FINISH (edge N+XLEN+1):
//     - Apply sign fixup: product negated if signs differ; quotient negated if signs differ;
//       remainder takes dividend sign.
//     - Select the result: MUL low XLEN; MULH/MULHSU/MULHU high XLEN; DIV/DIVU quotient;
//       REM/REMU remainder.
//     - Register result and rd_out, done=1, busy=0. done is high only the cycle after this edge.
//   Special cases, decided at accept; take FINISH_SPECIAL at edge N+1 (done after 1 edge):
//     - divisor==0: DIV/DIVU quotient=all ones; REM/REMU=op_a.
//     - DIV/REM with op_a=0x80000000, op_b=-1: quotient=0x80000000, remainder=0.
//     - Multiplies never take the special path.
//   Handshake:
//     - start while busy: ignored, no state change.
//     - start in the same cycle done is high: accepted (state IDLE); result holds old value
//       until the new FINISH.
//   Width rules: all arithmetic modulo 2^XLEN on output. MULH uses full 2*XLEN signed product.
//   Operand inputs need not stay stable after accept.
// TESTING
//   MUL 7 x 0xFFFFFFFD (-3), start at edge 0 -> done pulse after edge 33, result 0xFFFFFFEB.
//   MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE.
//   MULH 0x80000000 x 0x80000000 -> result 0x40000000.
//   MULHSU 0xFFFFFFFF x 2 -> result 0xFFFFFFFF.
//   DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   DIVU 5/0 -> 0xFFFFFFFF, done after 1 edge.
//   REM 5/0 -> 5.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done after 1 edge.
//   rd_in=9 with start pulsed again at cycle 10 -> second start ignored; rd_out=9 at done.
//   Reset asserted at cycle 15 of a DIV -> next cycle busy=0, done=0, result=0.
//     No done ever appears for the aborted op.
//   Back-to-back: start held high through done -> second op accepted in the done cycle.
//     Second done arrives XLEN+1 edges later with the correct value.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle on operand magnitudes, with sign fixup applied when the result is registered.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int            CW      = $clog2(XLEN);
  localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH,
    S_SPECIAL
  } state_t;

  function automatic logic [XLEN-1:0] cneg(input logic signed [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic signed [2*XLEN-1:0] v,
                                              input logic neg);
    return neg ? -v : v;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;

  // Accept-time decode, taken straight from the operand ports.
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_special_val;

  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_a_mag    = cneg(op_a, w_a_neg);
  assign w_b_mag    = cneg(op_b, w_b_neg);
  assign w_div_zero = w_is_div && (op_b == '0);
  assign w_div_ovf  = w_is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div_zero)
      w_special_val = funct3[1] ? op_a : '1;
    else if (w_div_ovf)
      w_special_val = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration step. Multiply keeps {hi, multiplier} and shifts right, so the carry of
  // the add drops into the top of hi. Divide keeps {remainder, dividend/quotient}.
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN-1:0] w_div_sub;
  logic            w_div_borrow;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;

  assign w_mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_div_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_div_borrow = w_div_shift < {1'b0, r_opnd};
  assign w_div_sub    = w_div_shift[XLEN-1:0] - r_opnd;

  always_comb begin
    w_step_hi = w_mul_sum[XLEN:1];
    w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (r_f3[2]) begin
      w_step_hi = w_div_borrow ? w_div_shift[XLEN-1:0] : w_div_sub;
      w_step_lo = {r_lo[XLEN-2:0], ~w_div_borrow};
    end
  end

  // Sign fixup and result selection for the FINISH edge.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin;

  assign w_prod = cneg2({r_hi, r_lo}, r_neg_q);
  assign w_quo  = cneg(r_lo, r_neg_q);
  assign w_rem  = cneg(r_hi, r_neg_r);

  always_comb begin
    w_fin = '0;
    case (r_f3)
      3'b000:                 w_fin = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fin = w_quo;
      default:                w_fin = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3    <= funct3;
            r_rd    <= rd_in;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_hi    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            if (w_special) begin
              r_lo    <= w_special_val;
              r_opnd  <= '0;
              r_state <= S_SPECIAL;
            end else if (w_is_div) begin
              r_lo    <= w_a_mag;
              r_opnd  <= w_b_mag;
              r_state <= S_RUN;
            end else begin
              r_lo    <= w_b_mag;
              r_opnd  <= w_a_mag;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_hi <= w_step_hi;
          r_lo <= w_step_lo;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          result  <= w_fin;
          rd_out  <= r_rd;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_SPECIAL: begin
          result  <= r_lo;
          rd_out  <= r_rd;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected result/rd/done-cycle into a
// queue, and a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int LAT_RUN  = XLEN + 1;
  localparam int LAT_SPEC = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    int unsigned     at;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done with result %h rd %0d, want no done", result, rd_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    if (busy !== 1'b0) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: got busy %b, want 0", busy);
    end
  endtask

  // Issue one operation at a negedge while idle; the accepting edge is the next posedge.
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd, input logic [XLEN-1:0] want, input int lat,
                       input bit expect_done);
    exp_t e;
    wait_idle();
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    if (expect_done) begin
      e.res = want;
      e.rd  = rd;
      e.at  = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h0BAD_F00D;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd",     {27'd0, rd_out}, 32'd0);

    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, LAT_RUN, 1'b1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, LAT_RUN, 1'b1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, LAT_RUN, 1'b1);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2,        5'd4,  32'hFFFF_FFFF, LAT_RUN, 1'b1);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'h0000_0000, LAT_RUN, 1'b1);
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0000_0001, LAT_RUN, 1'b1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFD, LAT_RUN, 1'b1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd8,  32'hFFFF_FFFF, LAT_RUN, 1'b1);
    issue(3'b101, 32'd100,      32'd7,         5'd10, 32'd14,        LAT_RUN, 1'b1);
    issue(3'b111, 32'd100,      32'd7,         5'd11, 32'd2,         LAT_RUN, 1'b1);
    issue(3'b101, 32'd5,        32'd0,         5'd12, 32'hFFFF_FFFF, LAT_SPEC, 1'b1);
    issue(3'b110, 32'd5,        32'd0,         5'd13, 32'd5,         LAT_SPEC, 1'b1);
    issue(3'b100, 32'd5,        32'd0,         5'd14, 32'hFFFF_FFFF, LAT_SPEC, 1'b1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, LAT_SPEC, 1'b1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, LAT_SPEC, 1'b1);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, LAT_RUN, 1'b1);

    // Second start while busy must be ignored.
    issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, LAT_RUN, 1'b1);
    repeat (8) @(negedge clk);
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd3;
    rd_in  = 5'd20;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Reset mid-divide: nothing may complete for the aborted op.
    issue(3'b100, 32'd1000, 32'd3, 5'd21, 32'd0, LAT_RUN, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);

    // Back-to-back with start held high through done.
    begin
      exp_t e;
      funct3 = 3'b011;
      op_a   = 32'h0001_0000;
      op_b   = 32'h0001_0000;
      rd_in  = 5'd22;
      start  = 1'b1;
      e.res = 32'd1;
      e.rd  = 5'd22;
      e.at  = cyc + 1 + LAT_RUN;
      q.push_back(e);
      @(negedge clk);
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      if (done !== 1'b1) begin
        n_chk++;
        n_err++;
        $display("FAIL b2b_first_done: got done %b, want 1", done);
      end
      funct3 = 3'b101;
      op_a   = 32'd100;
      op_b   = 32'd7;
      rd_in  = 5'd23;
      e.res = 32'd14;
      e.rd  = 5'd23;
      e.at  = cyc + 1 + LAT_RUN;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("b2b_accept_busy", {31'd0, busy}, 32'd1);
      check("b2b_result_held", result, 32'd1);
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("pending_expectations", q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
